// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX pipeline register layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rw;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] link;
    logic        reg_write;
    logic        mem_read;
  } id_ex_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one sync write port, r0 hardwired to 0.
// Define REGFILE_BYPASS_EN to make a same-cycle write visible on the read ports.
module regfile
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra_a_i,
  input  logic [4:0]  ra_b_i,
  output logic [31:0] rd_a_o,
  output logic [31:0] rd_b_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0][31:0] regs_q, regs_d;
  logic              wr_active;

  assign wr_active = we_i && (wa_i != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_active) begin
      regs_d[wa_i] = wd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_a_o = (ra_a_i == 5'd0) ? 32'd0 : regs_q[ra_a_i];
    rd_b_o = (ra_b_i == 5'd0) ? 32'd0 : regs_q[ra_b_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_active && (wa_i == ra_a_i)) rd_a_o = wd_i;
    if (wr_active && (wa_i == ra_b_i)) rd_b_o = wd_i;
`endif
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: register read, immediate extend, ID/EX register, branch/jump
// resolution and load-use stall. Optional REGFILE_BYPASS_EN enables regfile write-through.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rw,
  input  logic [4:0]  shamt,
  input  logic [15:0] immediate,
  input  logic [25:0] target,
  input  logic [31:0] pc,
  input  logic        register_write,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [5:0]  ex_op,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rw,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_link,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        stall,
  output logic        branch,
  output logic [31:0] branch_target
);

  localparam id_ex_t ExReset = '{pc: RESET_PC, default: '0};

  id_ex_t      ex_q, ex_d;
  logic        branch_q, branch_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic [31:0] rs_val, rt_val;
  logic [31:0] pc_plus4, imm_sext, imm_ext, br_taken_target;
  logic        capture;

  regfile u_regfile (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ra_a_i (rs),
    .ra_b_i (rt),
    .rd_a_o (rs_val),
    .rd_b_o (rt_val),
    .we_i   (wb_en),
    .wa_i   (wb_addr),
    .wd_i   (wb_data)
  );

  assign pc_plus4        = pc + 32'd4;
  assign imm_sext        = {{16{immediate[15]}}, immediate};
  assign br_taken_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  always_comb begin
    unique case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0000, immediate};
      OP_LUI:                   imm_ext = {immediate, 16'h0000};
      default:                  imm_ext = imm_sext;
    endcase
  end

  // The bubble inserted on a stall clears the hazard, so stall never exceeds one cycle.
  assign stall = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rw != 5'd0) &&
                 in_valid && ((ex_q.rw == rs) || (reads_rt(op) && (ex_q.rw == rt)));

  // A live redirect squashes whatever sits at the inputs, even if it would also stall.
  assign capture = in_valid && !stall && !branch_q;

  always_comb begin
    ex_d            = '0;
    branch_d        = 1'b0;
    branch_target_d = branch_target_q;
    if (capture) begin
      ex_d.valid     = 1'b1;
      ex_d.op        = op;
      ex_d.funct     = funct;
      ex_d.shamt     = shamt;
      ex_d.rw        = rw;
      ex_d.rs_val    = rs_val;
      ex_d.rt_val    = rt_val;
      ex_d.imm       = imm_ext;
      ex_d.pc        = pc;
      ex_d.reg_write = register_write;
      ex_d.mem_read  = is_load(op);
      if (op == OP_JAL) begin
        ex_d.rw        = REG_RA;
        ex_d.reg_write = 1'b1;
        ex_d.link      = pc_plus4;
      end
      if ((op == OP_J) || (op == OP_JAL)) begin
        branch_d        = 1'b1;
        branch_target_d = {pc_plus4[31:28], target, 2'b00};
      end else if ((op == OP_RTYPE) && (funct == FN_JR)) begin
        branch_d        = 1'b1;
        branch_target_d = rs_val;
      end else if (((op == OP_BEQ) && (rs_val == rt_val)) ||
                   ((op == OP_BNE) && (rs_val != rt_val))) begin
        branch_d        = 1'b1;
        branch_target_d = br_taken_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q            <= ExReset;
      branch_q        <= 1'b0;
      branch_target_q <= 32'd0;
    end else begin
      ex_q            <= ex_d;
      branch_q        <= branch_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_op         = ex_q.op;
  assign ex_funct      = ex_q.funct;
  assign ex_shamt      = ex_q.shamt;
  assign ex_rw         = ex_q.rw;
  assign ex_rs_val     = ex_q.rs_val;
  assign ex_rt_val     = ex_q.rt_val;
  assign ex_imm        = ex_q.imm;
  assign ex_pc         = ex_q.pc;
  assign ex_link       = ex_q.link;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign branch        = branch_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  localparam logic [31:0] RstPc = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rw, shamt;
  logic [15:0] immediate;
  logic [25:0] target;
  logic [31:0] pc;
  logic        register_write;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_shamt, ex_rw;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc, ex_link;
  logic        ex_reg_write, ex_mem_read, stall, branch;
  logic [31:0] branch_target;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.RESET_PC(RstPc)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .op             (op),
    .funct          (funct),
    .rs             (rs),
    .rt             (rt),
    .rw             (rw),
    .shamt          (shamt),
    .immediate      (immediate),
    .target         (target),
    .pc             (pc),
    .register_write (register_write),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .ex_valid       (ex_valid),
    .ex_op          (ex_op),
    .ex_funct       (ex_funct),
    .ex_shamt       (ex_shamt),
    .ex_rw          (ex_rw),
    .ex_rs_val      (ex_rs_val),
    .ex_rt_val      (ex_rt_val),
    .ex_imm         (ex_imm),
    .ex_pc          (ex_pc),
    .ex_link        (ex_link),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .stall          (stall),
    .branch         (branch),
    .branch_target  (branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; op = '0; funct = '0; rs = '0; rt = '0; rw = '0; shamt = '0;
    immediate = '0; target = '0; pc = '0; register_write = 1'b0;
  endtask

  task automatic dec(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                     input logic [4:0] t, input logic [4:0] w, input logic [15:0] im,
                     input logic [25:0] tg, input logic [31:0] p, input logic we);
    in_valid = 1'b1; op = o; funct = f; rs = s; rt = t; rw = w; shamt = 5'd0;
    immediate = im; target = tg; pc = p; register_write = we;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, RstPc);
    chk("rst_branch", 32'(branch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register writes, then addu v0,v1,v0
    wb(5'd3, 32'd5); step();
    wb(5'd2, 32'd7); step();
    wb_en = 1'b0;
    dec(6'h00, 6'h21, 5'd3, 5'd2, 5'd2, 16'h0, 26'h0, 32'h0000_0040, 1'b1);
    step();
    chk("addu_rs", ex_rs_val, 32'd5);
    chk("addu_rt", ex_rt_val, 32'd7);
    chk("addu_rw", 32'(ex_rw), 32'd2);
    chk("addu_we", 32'(ex_reg_write), 32'd1);
    chk("addu_valid", 32'(ex_valid), 32'd1);
    chk("addu_link", ex_link, 32'd0);

    // Same-cycle write/read of r4 (r4 was 0)
    wb(5'd4, 32'h99);
    dec(6'h00, 6'h21, 5'd4, 5'd0, 5'd5, 16'h0, 26'h0, 32'h0000_0044, 1'b1);
    step();
    wb_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rs", ex_rs_val, 32'h99);
`else
    chk("bypass_rs", ex_rs_val, 32'h0);
`endif

    // Immediate extension
    dec(6'h09, 6'h00, 5'd29, 5'd29, 5'd29, 16'hFFD0, 26'h0, 32'h48, 1'b1);
    step();
    chk("addiu_imm", ex_imm, 32'hFFFF_FFD0);
    dec(6'h0D, 6'h00, 5'd1, 5'd1, 5'd1, 16'hFFD0, 26'h0, 32'h4C, 1'b1);
    step();
    chk("ori_imm", ex_imm, 32'h0000_FFD0);
    dec(6'h0F, 6'h00, 5'd0, 5'd1, 5'd1, 16'h1234, 26'h0, 32'h50, 1'b1);
    step();
    chk("lui_imm", ex_imm, 32'h1234_0000);

    // jal 0x4020a0 at 0x00400010, then squashed follower
    dec(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0828, 32'h0040_0010, 1'b0);
    step();
    chk("jal_branch", 32'(branch), 32'd1);
    chk("jal_target", branch_target, 32'h0040_20A0);
    chk("jal_rw", 32'(ex_rw), 32'd31);
    chk("jal_link", ex_link, 32'h0040_0014);
    chk("jal_we", 32'(ex_reg_write), 32'd1);
    dec(6'h00, 6'h21, 5'd3, 5'd2, 5'd9, 16'h0, 26'h0, 32'h0040_0014, 1'b1);
    step();
    chk("jal_squash", 32'(ex_valid), 32'd0);
    chk("jal_pulse", 32'(branch), 32'd0);
    chk("jal_tgt_hold", branch_target, 32'h0040_20A0);

    // lw t0,0(sp) ; addu t1,t0,t0 -> one stall cycle
    dec(6'h23, 6'h00, 5'd29, 5'd8, 5'd8, 16'h0, 26'h0, 32'h100, 1'b1);
    step();
    chk("lw_memrd", 32'(ex_mem_read), 32'd1);
    dec(6'h00, 6'h21, 5'd8, 5'd8, 5'd9, 16'h0, 26'h0, 32'h104, 1'b1);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall_gone", 32'(stall), 32'd0);
    step();
    chk("lu_capt_valid", 32'(ex_valid), 32'd1);
    chk("lu_capt_rw", 32'(ex_rw), 32'd9);

    // I-type whose rt matches the load destination does not stall
    dec(6'h23, 6'h00, 5'd29, 5'd8, 5'd8, 16'h0, 26'h0, 32'h108, 1'b1);
    step();
    dec(6'h09, 6'h00, 5'd1, 5'd8, 5'd8, 16'h1, 26'h0, 32'h10C, 1'b1);
    #1;
    chk("itype_nostall", 32'(stall), 32'd0);
    // Load to r0 never stalls
    dec(6'h23, 6'h00, 5'd29, 5'd0, 5'd0, 16'h0, 26'h0, 32'h110, 1'b1);
    step();
    dec(6'h00, 6'h21, 5'd0, 5'd0, 5'd9, 16'h0, 26'h0, 32'h114, 1'b1);
    #1;
    chk("r0_nostall", 32'(stall), 32'd0);
    step();

    // beq equal (r3==r3), imm=4, pc=0x100
    dec(6'h04, 6'h00, 5'd3, 5'd3, 5'd0, 16'h0004, 26'h0, 32'h100, 1'b0);
    step();
    chk("beq_taken", 32'(branch), 32'd1);
    chk("beq_target", branch_target, 32'h114);
    idle();
    step();
    // beq unequal (5 vs 7)
    dec(6'h04, 6'h00, 5'd3, 5'd2, 5'd0, 16'h0004, 26'h0, 32'h100, 1'b0);
    step();
    chk("beq_nt", 32'(branch), 32'd0);
    chk("beq_nt_tgt", branch_target, 32'h114);
    // bne unequal, negative offset
    dec(6'h05, 6'h00, 5'd3, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h200, 1'b0);
    step();
    chk("bne_target", branch_target, 32'h200);
    idle();
    step();
    // jr r2
    dec(6'h00, 6'h08, 5'd2, 5'd0, 5'd0, 16'h0, 26'h0, 32'h300, 1'b0);
    step();
    chk("jr_branch", 32'(branch), 32'd1);
    chk("jr_target", branch_target, 32'd7);
    idle();
    step();

    // Reset in the middle of a stall
    dec(6'h23, 6'h00, 5'd29, 5'd8, 5'd8, 16'h0, 26'h0, 32'h400, 1'b1);
    step();
    dec(6'h00, 6'h21, 5'd8, 5'd0, 5'd9, 16'h0, 26'h0, 32'h404, 1'b1);
    #1;
    chk("mid_stall", 32'(stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_branch", 32'(branch), 32'd0);
    chk("arst_pc", ex_pc, RstPc);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    dec(6'h00, 6'h21, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 32'h500, 1'b1);
    step();
    chk("arst_r2", ex_rs_val, 32'd0);
    chk("arst_r3", ex_rt_val, 32'd0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute stage of the MIPS core, directly downstream of the fetch/decode control unit. Reads the 32×32 register file for the decoded fields, extends the immediate, and registers everything into the ID/EX pipeline register. Resolves jumps and branches, returning `branch`/`branch_target` to the fetch unit, and raises `stall` on load-use hazards.

## Interface
- `RESET_PC`, default 32'h0000_0000, value of `ex_pc` after reset
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `in_valid` in 1, decoded instruction present
- `op`, `funct` in 6 each, decoded opcode/function fields
- `rs`, `rt`, `rw`, `shamt` in 5 each, decoded source, destination and shift-amount fields
- `immediate` in 16, I-type immediate
- `target` in 26, J-type target
- `pc` in 32, address of the decoded instruction
- `register_write` in 1, instruction writes `rw`
- `wb_en` in 1, write-back enable
- `wb_addr` in 5, write-back address
- `wb_data` in 32, write-back data
- `ex_valid` out 1, stage holds a live instruction
- `ex_op`, `ex_funct` out 6 each
- `ex_shamt`, `ex_rw` out 5 each
- `ex_rs_val`, `ex_rt_val`, `ex_imm`, `ex_pc`, `ex_link` out 32 each
- `ex_reg_write`, `ex_mem_read` out 1 each
- `stall` out 1, combinational; hold fetch/decode this cycle
- `branch` out 1, registered redirect pulse
- `branch_target` out 32, registered redirect address

## Operation
- Capture: on each rising edge the stage register loads the input fields when `in_valid && !stall && !branch`. Otherwise it loads a bubble: `ex_valid`=0, `ex_reg_write`=0, `ex_mem_read`=0, all other fields 0.
- Register reads are combinational on `rs`/`rt`. The result is registered into `ex_rs_val`/`ex_rt_val`. Register 0 always reads 0, and writes to it are ignored.
- Register write: when `wb_en` is high and `wb_addr`≠0, `wb_data` is written at the clock edge.
- `ex_imm` by opcode:
  - `op` 0x0C/0x0D/0x0E: zero-extended immediate.
  - `op` 0x0F: {imm,16'h0}.
  - All other opcodes: sign-extended immediate.
- `ex_mem_read`=1 for `op` ∈ {0x20,0x21,0x23,0x24,0x25}.
- JAL (`op` 0x03): `ex_rw`=31, `ex_reg_write`=1, `ex_link`=pc+4. The core has no delay slot. `ex_link`=0 for all other instructions.
- Branch resolution uses the values captured in the same edge. `branch` is set on that edge, so it is high in the cycle `ex_valid` shows the branching instruction.
  - J/JAL (`op` 0x02/0x03): target = {pc+4[31:28], target, 2'b00}.
  - JR (`op` 0, `funct` 0x08): target = rs value.
  - BEQ (`op` 0x04) taken if rs_val==rt_val; BNE (`op` 0x05) taken if they differ. Taken target = pc+4+(sext(imm)<<2). Arithmetic is 32-bit modulo and the carry is discarded.
  - Not-taken branches leave `branch`=0 and `branch_target` unchanged.
- Load-use hazard: `stall`=1 when all of the following hold:
  - `ex_valid`, `ex_mem_read` and `ex_reg_write` are all 1;
  - `ex_rw`≠0;
  - `in_valid`=1;
  - `ex_rw` equals `rs`, or equals `rt` for R-type, store (`op` 0x28/0x29/0x2B) or BEQ/BNE.

## Timing
- Reset (`rst_n` low, asynchronous): all outputs 0, `ex_pc`=`RESET_PC`, and all 32 registers cleared to 0. A reset in the middle of a stall or branch clears both immediately.
- Decode-to-`ex_*` latency is 1 cycle.
- `branch` is a single-cycle pulse. The instruction presented at the inputs during the pulse is squashed (bubble).
- A load-use `stall` lasts exactly 1 cycle, because the bubble clears the hazard. The held instruction is re-presented by the upstream stage and captured on the next edge.
- `stall` and `branch` in the same cycle: `branch` wins and the input is squashed.
- Write-back and read of the same address in the same cycle: behaviour depends on `REGFILE_BYPASS_EN` (see Configuration).

## Configuration
- `REGFILE_BYPASS_EN` defined: a same-cycle write/read of the same nonzero address returns `wb_data` (write-through).
- `REGFILE_BYPASS_EN` undefined: the read returns the pre-write contents, and software must insert a gap instruction.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW;
  - FN_JR;
  - REG_RA=31;
  - the `id_ex_t` struct for the pipeline register.
- One sub-module, `regfile`: two asynchronous read ports and one synchronous write port, with reset clear and the optional bypass.

## Test plan
- Write r3=5 and r2=7 via the WB port, then decode `addu v0,v1,v0` → next cycle `ex_rs_val`=5, `ex_rt_val`=7, `ex_rw`=2, `ex_reg_write`=1.
- Decode `addiu sp,sp,-48` (imm 0xFFD0) → `ex_imm`=32'hFFFF_FFD0. Decode `ori` with imm 0xFFD0 → `ex_imm`=32'h0000_FFD0.
- Decode `jal 0x4020a0` at pc 0x00400010 → `branch`=1 for one cycle, `branch_target`=0x004020A0, `ex_rw`=31, `ex_link`=0x00400014. The next input is squashed (`ex_valid`=0 the following cycle).
- Decode `lw t0,0(sp)` followed by `addu t1,t0,t0` → `stall`=1 for one cycle and a bubble appears in the stage. The `addu` is captured one cycle later.
- Decode `beq` with equal operands, imm=4, pc=0x100 → `branch_target`=0x114. Repeat with unequal operands → `branch` stays 0.
- Assert `rst_n` low in the middle of a stall → `stall`, `branch` and `ex_valid` drop to 0 immediately, and r2 reads 0 afterwards.
